result_readout: RTL

Output-side counterpart of the sample-entry path: captures the finished regression results (intercept, slope, determinant, error flags) on a completion pulse and presents them one item at a time as sign + two BCD digits for the board's two-digit display. The user steps through items with the same `next`/enter-style button used for data entry. The block sits after the final `(XᵀX)⁻¹·Xᵀy` multiply. It replaces the combinational divide-by-10 with a multi-cycle subtract-by-10 converter.

---
 rtl/result_readout.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/result_readout.sv
// result_readout: latches the final regression results on a completion pulse
// and presents them one item at a time as sign + two BCD digits. The binary to
// BCD step is a serial subtract-by-10 converter, one tens step per cycle,
// saturating at 9,9 for magnitudes above 99.
module result_readout #(
  parameter int RESULT_WIDTH = 14
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [RESULT_WIDTH-1:0] intercept,
  input  logic [RESULT_WIDTH-1:0] slope,
  input  logic [RESULT_WIDTH-1:0] det,
  input  logic                    error_det,
  input  logic                    error_values,
  input  logic                    next,
  output logic                    busy,
  output logic                    valid,
  output logic [1:0]              item,
  output logic                    sign,
  output logic [3:0]              tens,
  output logic [3:0]              ones,
  output logic                    overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    SHOW = 2'd2
  } state_t;

  localparam logic [RESULT_WIDTH-1:0] ONE      = RESULT_WIDTH'(1);
  localparam logic [RESULT_WIDTH-1:0] TEN      = RESULT_WIDTH'(10);
  localparam logic [3:0]              BCD_ERR  = 4'hE;
  localparam logic [3:0]              BCD_NINE = 4'd9;
  localparam logic [1:0]              ITEM_ERR = 2'd3;

  state_t                  state;
  state_t                  state_n;
  logic                    next_d;
  logic [RESULT_WIDTH-1:0] intercept_q;
  logic [RESULT_WIDTH-1:0] slope_q;
  logic [RESULT_WIDTH-1:0] det_q;
  logic                    err_q;
  logic [RESULT_WIDTH-1:0] rem;
  logic [3:0]              tcnt;

  logic                    next_pulse;
  logic                    capture_err;
  logic                    advance;
  logic                    rem_ge10;
  logic                    tcnt_max;
  logic [1:0]              item_adv;
  logic [RESULT_WIDTH-1:0] load_val;
  logic [RESULT_WIDTH-1:0] load_abs;

  assign next_pulse  = next & ~next_d;
  assign capture_err = error_det | error_values;
  assign advance     = (state == SHOW) && next_pulse && !err_q;
  assign rem_ge10    = (rem >= TEN);
  assign tcnt_max    = (tcnt == BCD_NINE);
  assign item_adv    = (item == 2'd2) ? 2'd0 : item + 2'd1;

  // Select the value to feed the converter and take its magnitude.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    load_val = intercept;
    if (!start) begin
      case (item_adv)
        2'd1:    load_val = slope_q;
        2'd2:    load_val = det_q;
        default: load_val = intercept_q;
      endcase
    end
    // Unsigned result, so the most negative input maps to 2^(W-1) without wrapping.
    load_abs = load_val[RESULT_WIDTH-1] ? (~load_val + ONE) : load_val;
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state logic; a capture pulse overrides everything else.
  always_comb begin
    state_n = state;
    if (start) begin
      state_n = capture_err ? SHOW : CONV;
    end else begin
      case (state)
        IDLE: state_n = IDLE;
        CONV: if (!rem_ge10 || tcnt_max) state_n = SHOW;
        SHOW: if (advance) state_n = CONV;
        default: state_n = IDLE;
      endcase
    end
  end

  // Status outputs decoded from the state.
  always_comb begin
    busy  = (state != IDLE);
    valid = (state == SHOW);
  end

  // Result latches, converter datapath and displayed digits.
  always_ff @(posedge clk) begin
    if (rst) begin
      next_d      <= 1'b0;
      intercept_q <= '0;
      slope_q     <= '0;
      det_q       <= '0;
      err_q       <= 1'b0;
      rem         <= '0;
      tcnt        <= '0;
      item        <= '0;
      sign        <= 1'b0;
      tens        <= '0;
      ones        <= '0;
      overflow    <= 1'b0;
    end else begin
      next_d <= next;
      if (start) begin
        intercept_q <= intercept;
        slope_q     <= slope;
        det_q       <= det;
        err_q       <= capture_err;
        overflow    <= 1'b0;
        tcnt        <= '0;
        if (capture_err) begin
          item <= ITEM_ERR;
          sign <= 1'b0;
          tens <= BCD_ERR;
          ones <= BCD_ERR;
        end else begin
          item <= 2'd0;
          sign <= load_val[RESULT_WIDTH-1];
          rem  <= load_abs;
        end
      end else if (advance) begin
        item     <= item_adv;
        sign     <= load_val[RESULT_WIDTH-1];
        rem      <= load_abs;
        tcnt     <= '0;
        overflow <= 1'b0;
      end else if (state == CONV) begin
        if (rem_ge10) begin
          if (tcnt_max) begin
            tens     <= BCD_NINE;
            ones     <= BCD_NINE;
            overflow <= 1'b1;
          end else begin
            rem  <= rem - TEN;
            tcnt <= tcnt + 4'd1;
          end
        end else begin
          tens <= tcnt;
          ones <= rem[3:0];
        end
      end
    end
  end

endmodule
